// File: rtl/toggle_counter.sv
// Purpose: WIDTH-bit register with a per-bit toggle bank, up/down counting, parallel load and boundary flags.
// Latency: one cycle; q, qbar, tc and ovf are all flop outputs and change on the rising edge after the inputs.
// Backpressure: none; en gates mode updates, load overrides en/mode, and rst overrides everything.
module toggle_counter #(
    parameter int unsigned     WIDTH    = 8,
    parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
    parameter bit              SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] t,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             tc,
    output logic             ovf
);

    typedef enum logic [1:0] {
        MODE_HOLD   = 2'b00,
        MODE_TOGGLE = 2'b01,
        MODE_UP     = 2'b10,
        MODE_DOWN   = 2'b11
    } mode_e;

    // Largest value representable in WIDTH bits, kept in 64 bits so WIDTH=32 does not overflow.
    localparam longint unsigned FULL_MAX   = (64'd1 << WIDTH) - 64'd1;
    // When the ceiling is the full range nothing can sit above it, so the above-ceiling compares vanish.
    localparam bit              FULL_RANGE = (MAX_VAL == FULL_MAX);
    localparam logic [WIDTH-1:0] MAX_Q     = MAX_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] ONE_Q     = WIDTH'(1);

    // Reject parameter sets that cannot be built.
    generate
        if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
            $error("toggle_counter: WIDTH must be in 1..32");
        end
        if (MAX_VAL == 64'd0 || MAX_VAL > FULL_MAX) begin : g_bad_max
            $error("toggle_counter: MAX_VAL must satisfy 0 < MAX_VAL <= 2**WIDTH-1");
        end
    endgenerate

    logic [WIDTH-1:0] q_nxt;
    logic             tc_nxt;
    logic             ovf_nxt;
    logic             q_above_max;    // q > MAX_VAL, only reachable through the toggle bank
    logic             q_below_max;    // q < MAX_VAL, room left to count up
    logic             q_is_zero;
    logic             lv_above_max;   // load data needs clamping to the ceiling
    logic [WIDTH-1:0] load_clamped;
    logic [WIDTH-1:0] up_wrap_val;    // value taken on the up-boundary event
    logic [WIDTH-1:0] dn_wrap_val;    // value taken on the down-boundary event
    mode_e            mode_sel;

    // Unsigned ceiling compares; tied off when the ceiling covers the whole register range.
    generate
        if (FULL_RANGE) begin : g_full_range
            assign q_above_max  = 1'b0;
            assign lv_above_max = 1'b0;
        end else begin : g_part_range
            assign q_above_max  = (q > MAX_Q);
            assign lv_above_max = (load_val > MAX_Q);
        end
    endgenerate

    assign q_below_max  = (q < MAX_Q);
    assign q_is_zero    = (q == '0);
    assign load_clamped = lv_above_max ? MAX_Q : load_val;
    assign up_wrap_val  = SATURATE ? MAX_Q : '0;
    assign dn_wrap_val  = SATURATE ? '0 : MAX_Q;
    assign mode_sel     = mode_e'(mode);

    // Next-state decode: load beats en, en gates the mode operation; tc defaults low so it only pulses.
    always_comb begin
        q_nxt   = q;
        tc_nxt  = 1'b0;
        ovf_nxt = ovf;
        if (load) begin
            q_nxt   = load_clamped;
            ovf_nxt = 1'b0;
        end else if (en) begin
            case (mode_sel)
                MODE_TOGGLE: begin
                    // Ceiling deliberately not applied: the toggle bank can push q above MAX_VAL.
                    q_nxt = q ^ t;
                end
                MODE_UP: begin
                    if (q_below_max) begin
                        q_nxt = q + ONE_Q;
                    end else begin
                        q_nxt   = up_wrap_val;
                        tc_nxt  = 1'b1;
                        ovf_nxt = 1'b1;
                    end
                end
                MODE_DOWN: begin
                    if (q_above_max) begin
                        // Pull an out-of-range value back to the ceiling; not a boundary event.
                        q_nxt = MAX_Q;
                    end else if (!q_is_zero) begin
                        q_nxt = q - ONE_Q;
                    end else begin
                        q_nxt   = dn_wrap_val;
                        tc_nxt  = 1'b1;
                        ovf_nxt = 1'b1;
                    end
                end
                default: begin
                    q_nxt = q;
                end
            endcase
        end
    end

    // State and complement registers; qbar gets its own flop so it carries no inverter after the q flop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q    <= '0;
            qbar <= '1;
        end else begin
            q    <= q_nxt;
            qbar <= ~q_nxt;
        end
    end

    // Terminal-count pulse and sticky boundary flag registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tc  <= 1'b0;
            ovf <= 1'b0;
        end else begin
            tc  <= tc_nxt;
            ovf <= ovf_nxt;
        end
    end

endmodule

// File: tb/tb_toggle_counter.sv
// Bench for toggle_counter: four parameterisations share one stimulus stream.
// Each edge is predicted from the behavioural rules with integer arithmetic.
// Outputs are sampled 1 time unit after the rising edge.
module tb_toggle_counter;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [1:0] mode;
    logic [7:0] t;
    logic       load;
    logic [7:0] load_val;

    // Instance 0: WIDTH=8, full range, wrap.
    logic [7:0] q0, qb0;
    logic       tc0, ovf0;
    // Instance 1: WIDTH=8, MAX_VAL=9, wrap.
    logic [7:0] q1, qb1;
    logic       tc1, ovf1;
    // Instance 2: WIDTH=8, MAX_VAL=9, saturate.
    logic [7:0] q2, qb2;
    logic       tc2, ovf2;
    // Instance 3: WIDTH=1, MAX_VAL=1, wrap (T flip-flop in mode 01).
    logic [0:0] q3, qb3;
    logic       tc3, ovf3;

    int n_checks = 0;
    int n_fail   = 0;

    // Model state and per-instance parameters.
    int m_q   [4];
    int m_tc  [4];
    int m_ovf [4];
    int p_w   [4] = '{8, 8, 8, 1};
    int p_max [4] = '{255, 9, 9, 1};
    int p_sat [4] = '{0, 0, 1, 0};

    always #5 clk = ~clk;

    toggle_counter #(.WIDTH(8)) dut0 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .t(t), .load(load), .load_val(load_val),
        .q(q0), .qbar(qb0), .tc(tc0), .ovf(ovf0));

    toggle_counter #(.WIDTH(8), .MAX_VAL(9), .SATURATE(1'b0)) dut1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .t(t), .load(load), .load_val(load_val),
        .q(q1), .qbar(qb1), .tc(tc1), .ovf(ovf1));

    toggle_counter #(.WIDTH(8), .MAX_VAL(9), .SATURATE(1'b1)) dut2 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .t(t), .load(load), .load_val(load_val),
        .q(q2), .qbar(qb2), .tc(tc2), .ovf(ovf2));

    toggle_counter #(.WIDTH(1), .MAX_VAL(1), .SATURATE(1'b0)) dut3 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .t(t[0:0]), .load(load), .load_val(load_val[0:0]),
        .q(q3), .qbar(qb3), .tc(tc3), .ovf(ovf3));

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int obs_q(input int i);
        case (i)
            0: return int'(q0);
            1: return int'(q1);
            2: return int'(q2);
            default: return int'(q3);
        endcase
    endfunction

    function automatic int obs_qb(input int i);
        case (i)
            0: return int'(qb0);
            1: return int'(qb1);
            2: return int'(qb2);
            default: return int'(qb3);
        endcase
    endfunction

    function automatic int obs_tc(input int i);
        case (i)
            0: return int'(tc0);
            1: return int'(tc1);
            2: return int'(tc2);
            default: return int'(tc3);
        endcase
    endfunction

    function automatic int obs_ovf(input int i);
        case (i)
            0: return int'(ovf0);
            1: return int'(ovf1);
            2: return int'(ovf2);
            default: return int'(ovf3);
        endcase
    endfunction

    function automatic int mask_of(input int i);
        return (1 << p_w[i]) - 1;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_q[i] = 0; m_tc[i] = 0; m_ovf[i] = 0;
        end
    endtask

    // One rising edge of the behavioural rules, using the inputs currently applied.
    task automatic model_edge();
        for (int i = 0; i < 4; i++) begin
            int mk, mx, lv;
            mk = mask_of(i);
            mx = p_max[i];
            m_tc[i] = 0;
            if (rst) begin
                m_q[i] = 0; m_ovf[i] = 0;
            end else if (load) begin
                lv = int'(load_val) & mk;
                m_q[i]   = (lv < mx) ? lv : mx;
                m_ovf[i] = 0;
            end else if (en) begin
                if (mode == 2'd1) begin
                    m_q[i] = m_q[i] ^ (int'(t) & mk);
                end else if (mode == 2'd2) begin
                    if (m_q[i] < mx) m_q[i] = m_q[i] + 1;
                    else begin
                        m_q[i] = p_sat[i] ? mx : 0; m_tc[i] = 1; m_ovf[i] = 1;
                    end
                end else if (mode == 2'd3) begin
                    if (m_q[i] > mx) m_q[i] = mx;
                    else if (m_q[i] > 0) m_q[i] = m_q[i] - 1;
                    else begin
                        m_q[i] = p_sat[i] ? 0 : mx; m_tc[i] = 1; m_ovf[i] = 1;
                    end
                end
            end
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("%s.q[%0d]", tag, i),    obs_q(i),   m_q[i]);
            check($sformatf("%s.qbar[%0d]", tag, i), obs_qb(i),  (~m_q[i]) & mask_of(i));
            check($sformatf("%s.tc[%0d]", tag, i),   obs_tc(i),  m_tc[i]);
            check($sformatf("%s.ovf[%0d]", tag, i),  obs_ovf(i), m_ovf[i]);
        end
    endtask

    // Advance one edge, update the model, sample 1 unit later and compare everything.
    task automatic step(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    task automatic drive(input logic l, input logic [7:0] lv, input logic e,
                         input logic [1:0] m, input logic [7:0] tt);
        load = l; load_val = lv; en = e; mode = m; t = tt;
    endtask

    initial begin
        rst = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 2'b00, 8'h00);
        model_reset();
        #1;
        check_all("reset");
        #10;
        rst = 1'b0;

        // Toggle bank on 0x0F with t=0x3C gives 0x33.
        drive(1'b1, 8'h0F, 1'b0, 2'b00, 8'h00);
        step("load0f");
        drive(1'b0, 8'h00, 1'b1, 2'b01, 8'h3C);
        step("toggle");
        check("toggle_q0", int'(q0), 32'h33);
        check("toggle_qb0", int'(qb0), 32'hCC);
        check("toggle_tc0", int'(tc0), 0);

        // Wrap up from 8 with ceiling 9.
        drive(1'b1, 8'd8, 1'b0, 2'b00, 8'h00);
        step("load8");
        drive(1'b0, 8'd0, 1'b1, 2'b10, 8'h00);
        step("up1");
        check("wrap_q_1", int'(q1), 9);
        check("wrap_tc_1", int'(tc1), 0);
        step("up2");
        check("wrap_q_2", int'(q1), 0);
        check("wrap_tc_2", int'(tc1), 1);
        check("wrap_ovf_2", int'(ovf1), 1);
        step("up3");
        check("wrap_q_3", int'(q1), 1);
        check("wrap_tc_3", int'(tc1), 0);
        check("wrap_ovf_3", int'(ovf1), 1);

        // Saturating down from 1.
        drive(1'b1, 8'd1, 1'b0, 2'b00, 8'h00);
        step("load1");
        drive(1'b0, 8'd0, 1'b1, 2'b11, 8'h00);
        step("dn1");
        check("sat_q_1", int'(q2), 0);
        check("sat_tc_1", int'(tc2), 0);
        step("dn2");
        check("sat_q_2", int'(q2), 0);
        check("sat_tc_2", int'(tc2), 1);
        step("dn3");
        check("sat_q_3", int'(q2), 0);
        check("sat_tc_3", int'(tc2), 1);
        check("sat_ovf_3", int'(ovf2), 1);

        // Load wins over en/mode and clamps to the ceiling.
        drive(1'b1, 8'hC8, 1'b1, 2'b10, 8'h00);
        step("prio");
        check("prio_q", int'(q1), 9);
        check("prio_tc", int'(tc1), 0);
        check("prio_ovf", int'(ovf1), 0);
        check("prio_q0", int'(q0), 32'hC8);

        // Enable low freezes count mode.
        drive(1'b0, 8'h00, 1'b0, 2'b10, 8'h00);
        for (int k = 0; k < 5; k++) begin
            step("engate");
            check("engate_q0", int'(q0), 32'hC8);
            check("engate_tc0", int'(tc0), 0);
        end

        // Asynchronous reset mid-count at 0x5A, then a load pending under reset is dropped.
        drive(1'b1, 8'h5A, 1'b0, 2'b00, 8'h00);
        step("load5a");
        drive(1'b0, 8'h00, 1'b1, 2'b10, 8'h00);
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        check("arst_q0", int'(q0), 0);
        check("arst_qb0", int'(qb0), 32'hFF);
        check("arst_tc0", int'(tc0), 0);
        check("arst_ovf0", int'(ovf0), 0);
        drive(1'b1, 8'h77, 1'b1, 2'b10, 8'h00);
        step("rst_load");
        check("rst_load_q0", int'(q0), 0);
        #2;
        rst = 1'b0;
        step("post_rst");
        check("post_rst_q0", int'(q0), 32'h77);

        // Randomised traffic against the model; WIDTH=1 instance exercises the T flip-flop.
        for (int k = 0; k < 400; k++) begin
            drive(($urandom_range(0, 9) == 0), 8'($urandom), ($urandom_range(0, 9) < 8),
                  2'($urandom), 8'($urandom));
            step("rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Absolute time bound so the bench always ends.
    initial begin
        #200000;
        $display("FAIL timeout n_checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/toggle_counter.md
TOGGLE_COUNTER -- requirements
Module: toggle_counter

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the register width in bits (legal range 1..32).
REQ-002 The module SHALL have parameter MAX_VAL, default 2**WIDTH-1, giving the count ceiling; it SHALL satisfy 0 < MAX_VAL <= 2**WIDTH-1.
REQ-003 The module SHALL have parameter SATURATE, default 0, where 0 selects wrap at the boundaries and 1 selects saturation.
REQ-004 The module SHALL have port clk, input, 1 bit: the clock; all state changes on its rising edge.
REQ-005 The module SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 The module SHALL have port en, input, 1 bit: update enable for the mode operations.
REQ-007 The module SHALL have port mode, input, 2 bits: 00 hold, 01 toggle-bank, 10 count up, 11 count down.
REQ-008 The module SHALL have port t, input, WIDTH bits: per-bit toggle requests, used in mode 01 only.
REQ-009 The module SHALL have port load, input, 1 bit: synchronous parallel-load strobe.
REQ-010 The module SHALL have port load_val, input, WIDTH bits: the parallel-load data.
REQ-011 The module SHALL have port q, output, WIDTH bits: the registered state.
REQ-012 The module SHALL have port qbar, output, WIDTH bits: a registered bitwise complement of q.
REQ-013 The module SHALL have port tc, output, 1 bit: registered one-cycle terminal-count pulse.
REQ-014 The module SHALL have port ovf, output, 1 bit: sticky boundary flag.

Function
REQ-015 Every output SHALL be driven directly from a flop, with no combinational path from any input to any output.
REQ-016 qbar SHALL equal ~q on every cycle, updated on the same edge as q.
REQ-017 On each rising edge the priority SHALL be rst, then load, then en, then mode.
REQ-018 With load=1: q <= min(load_val, MAX_VAL); tc <= 0; ovf <= 0; en, mode and t ignored.
REQ-019 With load=0 and en=0: q and ovf hold; tc <= 0.
REQ-020 In mode 00 with en=1: q and ovf hold; tc <= 0.
REQ-021 In mode 01 with en=1: q <= q ^ t; bit i toggles iff t[i]=1, else holds; MAX_VAL not applied; tc <= 0; ovf holds.
REQ-022 In mode 10 with en=1 and q < MAX_VAL: q <= q+1; tc <= 0.
REQ-023 In mode 10 with en=1 and q >= MAX_VAL (the up-boundary event): q <= 0 when SATURATE=0, or q <= MAX_VAL when SATURATE=1.
REQ-024 In mode 11 with en=1 and q > MAX_VAL: q <= MAX_VAL; this is not a boundary event.
REQ-025 In mode 11 with en=1 and 0 < q <= MAX_VAL: q <= q-1; tc <= 0.
REQ-026 In mode 11 with en=1 and q = 0 (the down-boundary event): q <= MAX_VAL when SATURATE=0, or q <= 0 when SATURATE=1.
REQ-027 On any boundary event: tc <= 1 for exactly one cycle, coincident with the new q; ovf <= 1.
REQ-028 Holding count mode at a boundary with SATURATE=1 SHALL pulse tc again on every enabled edge, making tc a continuous level.
REQ-029 Arithmetic SHALL be modulo 2**WIDTH internally, with no carry-out beyond WIDTH bits; boundary detection SHALL use unsigned compares.
REQ-030 A mode change between edges SHALL take effect on the next enabled edge, with no pipeline or latency beyond one cycle.
REQ-031 With WIDTH=1, MAX_VAL=1 and mode 01, the block SHALL behave as a T flip-flop: q toggles when t=1 and en=1.

Reset
REQ-032 rst=1 SHALL force, asynchronously and independent of clk: q=0, qbar=all ones, tc=0, ovf=0.
REQ-033 Reset asserted mid-count SHALL abandon the operation; a load pending on the same edge SHALL be discarded.
REQ-034 After rst deasserts, the first rising edge SHALL apply normal priority.

Verification
REQ-035 Reset: WIDTH=8, assert rst mid-count at q=0x5A, no clock edge -> q=0x00, qbar=0xFF, tc=0, ovf=0 immediately.
REQ-036 Toggle bank: q=0x0F, mode=01, en=1, t=0x3C -> after one edge q=0x33, qbar=0xCC, tc=0.
REQ-037 Wrap up: MAX_VAL=9, SATURATE=0, load 8, mode=10 for 3 edges -> q = 9, 0, 1; tc high only with q=0; ovf=1 thereafter.
REQ-038 Saturate down: SATURATE=1, load 1, mode=11 for 3 edges -> q = 0, 0, 0; tc = 0, 1, 1; ovf set.
REQ-039 Priority/clamp: MAX_VAL=9, load=1 with load_val=0xC8, en=1, mode=10 in the same cycle -> q=9, tc=0, ovf cleared.
REQ-040 Enable gating: en=0 with mode=10 for 5 edges -> q unchanged, tc=0.
